serial_adder_nbit: RTL and testbench



---
 rtl/serial_adder_nbit.sv | 103 ++++++++++
 tb/tb_serial_adder_nbit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: multi-cycle LSB-first adder/subtractor, DIGIT bits per clock, start/busy/done handshake
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   carry_q, carry_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic                   cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [DIGIT:0]         slice;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                   accept, last;
    assign accept  = state_q == IDLE && start;
    assign last    = state_q == RUN && cnt_q == CW'(N - 1);
    assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign res_cat = {slice[DIGIT-1:0], res_q};
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    always_comb state_d = state_q == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = last;
        if (accept) begin
            a_d     = A;
            b_d     = B ^ {WIDTH{Sub}};
            carry_d = Cin ^ Sub;
            amsb_d  = A[WIDTH-1];
            bmsb_d  = B[WIDTH-1] ^ Sub;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = slice[DIGIT];
            res_d   = WIDTH'(res_cat >> DIGIT);
            cnt_d   = cnt_q + 1'b1;
        end
        if (last) begin
            sum_d  = res_d;
            cout_d = slice[DIGIT];
            ovf_d  = amsb_q == bmsb_q && res_d[WIDTH-1] != amsb_q;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    always_comb begin
        busy = state_q == RUN;
        done = done_q;
        Sum  = sum_q;
        Cout = cout_q;
        Ovf  = ovf_q;
    end
endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: vector table, hand-written corner sequences and random compare across four configurations
module tb_serial_adder_nbit;
    typedef struct packed {logic [15:0] sum; logic cout; logic ovf;} res_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic c; logic s; logic [7:0] sum; logic cout; logic ovf;} vec_t;
    logic        clk, rst, cin, sub;
    logic [15:0] opa, opb, s16;
    logic [7:0]  s8 [3];
    logic        st [4];
    logic        bs [4];
    logic        dn [4];
    logic        pdn [4];
    logic        co [4];
    logic        ov [4];
    res_t        q [4][$];
    int          nn [4] = '{8, 4, 1, 4};
    int          ww [4] = '{8, 8, 8, 16};
    int          checks = 0, failures = 0;
    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(st[0]), .A(opa[7:0]), .B(opb[7:0]), .Cin(cin), .Sub(sub),
        .busy(bs[0]), .done(dn[0]), .Sum(s8[0]), .Cout(co[0]), .Ovf(ov[0]));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(2)) u1 (.clk(clk), .rst(rst), .start(st[1]), .A(opa[7:0]), .B(opb[7:0]), .Cin(cin), .Sub(sub),
        .busy(bs[1]), .done(dn[1]), .Sum(s8[1]), .Cout(co[1]), .Ovf(ov[1]));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u2 (.clk(clk), .rst(rst), .start(st[2]), .A(opa[7:0]), .B(opb[7:0]), .Cin(cin), .Sub(sub),
        .busy(bs[2]), .done(dn[2]), .Sum(s8[2]), .Cout(co[2]), .Ovf(ov[2]));
    serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) u3 (.clk(clk), .rst(rst), .start(st[3]), .A(opa), .B(opb), .Cin(cin), .Sub(sub),
        .busy(bs[3]), .done(dn[3]), .Sum(s16), .Cout(co[3]), .Ovf(ov[3]));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        res_t   r;
        longint mask, ua, ub, sa, sb, full, rs;
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = ua >= (longint'(1) << (w - 1)) ? ua - (longint'(1) << w) : ua;
        sb = ub >= (longint'(1) << (w - 1)) ? ub - (longint'(1) << w) : ub;
        if (!s) begin
            full = ua + ub + longint'(c);
            r.cout = full > mask;
            rs = sa + sb + longint'(c);
        end else begin
            full = ua - ub - longint'(c) + (longint'(1) << w);
            r.cout = ua >= ub + longint'(c);
            rs = sa - sb - longint'(c);
        end
        r.sum = 16'(full & mask);
        r.ovf = rs > (longint'(1) << (w - 1)) - 1 || rs < -(longint'(1) << (w - 1));
        return r;
    endfunction
    function automatic logic [15:0] sum_of(input int i);
        return i == 3 ? s16 : {8'h00, s8[i]};
    endfunction
    always @(negedge clk)
        for (int i = 0; i < 4; i++) begin
            if (dn[i]) begin
                chk($sformatf("done_width%0d", i), {31'b0, pdn[i]}, 0);
                if (q[i].size() == 0) chk($sformatf("unexpected_done%0d", i), 1, 0);
                else begin
                    res_t e;
                    e = q[i].pop_front();
                    chk($sformatf("sum%0d", i), {16'h0, sum_of(i)}, {16'h0, e.sum});
                    chk($sformatf("cout%0d", i), {31'b0, co[i]}, {31'b0, e.cout});
                    chk($sformatf("ovf%0d", i), {31'b0, ov[i]}, {31'b0, e.ovf});
                end
            end
            pdn[i] = dn[i];
        end
    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn[i] && n < 200);
        if (!dn[i]) chk($sformatf("timeout%0d", i), 0, 1);
    endtask
    task automatic run(input int i, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, input res_t e);
        int n;
        @(negedge clk);
        opa = a; opb = b; cin = c; sub = s; st[i] = 1;
        q[i].push_back(e);
        @(negedge clk);
        st[i] = 0;
        chk($sformatf("busy%0d", i), {31'b0, bs[i]}, 1);
        wait_done(i, n);
        chk($sformatf("latency%0d", i), n, nn[i]);
    endtask
    initial begin
        vec_t vt [7];
        int   n, m;
        vt[0] = '{8'h5A, 8'h33, 0, 0, 8'h8D, 0, 1};
        vt[1] = '{8'hFF, 8'h01, 1, 0, 8'h01, 1, 0};
        vt[2] = '{8'h10, 8'h20, 0, 1, 8'hF0, 0, 0};
        vt[3] = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1};
        vt[4] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
        vt[5] = '{8'h00, 8'h00, 1, 1, 8'hFF, 0, 0};
        vt[6] = '{8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0};
        rst = 1; cin = 0; sub = 0; opa = 0; opb = 0;
        for (int i = 0; i < 4; i++) begin st[i] = 0; pdn[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bs[0]}, 0);
        chk("rst_done", {31'b0, dn[0]}, 0);
        chk("rst_sum", {24'h0, s8[0]}, 0);
        chk("rst_cout", {31'b0, co[0]}, 0);
        chk("rst_ovf", {31'b0, ov[0]}, 0);
        chk("rst_sum16", {16'h0, s16}, 0);
        rst = 0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 7; k++)
                run(i, {8'h0, vt[k].a}, {8'h0, vt[k].b}, vt[k].c, vt[k].s, '{{8'h0, vt[k].sum}, vt[k].cout, vt[k].ovf});
        // back-to-back: start in the done cycle, previous result must hold until completion
        run(0, 16'h80, 16'h01, 0, 1, '{16'h7F, 1, 1});
        opa = 16'h01; opb = 16'h01; cin = 0; sub = 0; st[0] = 1;
        q[0].push_back(model(8, 16'h01, 16'h01, 0, 0));
        @(negedge clk);
        st[0] = 0;
        chk("b2b_done_drop", {31'b0, dn[0]}, 0);
        chk("b2b_busy", {31'b0, bs[0]}, 1);
        chk("b2b_sum_held", {24'h0, s8[0]}, 32'h7F);
        chk("b2b_cout_held", {31'b0, co[0]}, 1);
        chk("b2b_ovf_held", {31'b0, ov[0]}, 1);
        wait_done(0, n);
        chk("b2b_latency", n, 8);
        // start held high with operands changing mid-run
        @(negedge clk);
        opa = 16'h11; opb = 16'h22; st[0] = 1;
        q[0].push_back(model(8, 16'h11, 16'h22, 0, 0));
        @(negedge clk);
        m = 0;
        repeat (3) begin
            @(negedge clk);
            m++;
            opa = 16'($urandom); opb = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            chk("hold_busy", {31'b0, bs[0]}, 1);
        end
        opa = 16'h40; opb = 16'h02; cin = 0; sub = 0;
        wait_done(0, n);
        chk("hold_latency", m + n, 8);
        q[0].push_back(model(8, 16'h40, 16'h02, 0, 0));
        @(negedge clk);
        st[0] = 0;
        chk("hold_rearm_busy", {31'b0, bs[0]}, 1);
        wait_done(0, n);
        chk("hold_rearm_latency", n, 8);
        // asynchronous abort three edges into a run
        @(negedge clk);
        opa = 16'h0F; opb = 16'h01; st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        repeat (3) @(negedge clk);
        chk("abort_pre_sum", {24'h0, s8[0]}, 32'h42);
        #1 rst = 1;
        #1;
        chk("abort_busy", {31'b0, bs[0]}, 0);
        chk("abort_done", {31'b0, dn[0]}, 0);
        chk("abort_sum", {24'h0, s8[0]}, 0);
        chk("abort_cout", {31'b0, co[0]}, 0);
        chk("abort_ovf", {31'b0, ov[0]}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, dn[0]}, 0);
        end
        rst = 0;
        run(0, 16'h0F, 16'h01, 0, 0, '{16'h10, 0, 0});
        run(3, 16'h1234, 16'h0FCD, 0, 0, '{16'h2201, 0, 0});
        for (int i = 0; i < 4; i++)
            repeat (25) begin
                logic [15:0] a, b;
                logic        c, s;
                a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
                run(i, a, b, c, s, model(ww[i], a, b, c, s));
            end
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("q_empty%0d", i), q[i].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
